// File: rtl/spi_reg_pkg.sv
//------------------------------------------------------------------------------
// Module : spi_reg_pkg
// Brief  : Shared types and constants for the SPI register bridge.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } bridge_st_t;

  localparam int              CMD_RD_BIT = 7;
  localparam int              ADDR_W     = 7;
  localparam logic [ADDR_W-1:0] STAT_BASE = 7'h40;

endpackage

`default_nettype wire

// File: rtl/spi_reg_bridge_if.sv
//------------------------------------------------------------------------------
// Module : spi_reg_bridge_if
// Brief  : Byte-level link between the SPI slave deserializer and the bridge.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface spi_reg_bridge_if;

  logic       frm_start_i;
  logic       frm_end_i;
  logic       rx_valid_i;
  logic [7:0] rx_data_i;
  logic [7:0] tx_data_o;

  // master: the deserializer side; slave: the register bridge
  modport master (
    output frm_start_i,
    output frm_end_i,
    output rx_valid_i,
    output rx_data_i,
    input  tx_data_o
  );

  modport slave (
    input  frm_start_i,
    input  frm_end_i,
    input  rx_valid_i,
    input  rx_data_i,
    output tx_data_o
  );

endinterface

`default_nettype wire

// File: rtl/spi_reg_rdmux.sv
//------------------------------------------------------------------------------
// Module : spi_reg_rdmux
// Brief  : Combinational readback select: RW registers, RO status or unmapped.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_reg_rdmux
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS  = 8,
  parameter int         NUM_STAT  = 4,
  parameter logic [7:0] UNMAP_VAL = 8'hEE
) (
  input  wire logic [ADDR_W-1:0]     addr,
  input  wire logic [8*NUM_REGS-1:0] regs,
  input  wire logic [8*NUM_STAT-1:0] stat,
  output      logic [7:0]            rdata
);

  // Register and status windows never overlap, so the last match wins safely.
  always_comb begin
    rdata = UNMAP_VAL;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) rdata = regs[8*i +: 8];
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      if (addr == STAT_BASE + ADDR_W'(j)) rdata = stat[8*j +: 8];
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_reg_bridge.sv
//------------------------------------------------------------------------------
// Module : spi_reg_bridge
// Brief  : SPI command decoder driving an RW register bank and status readback.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS  = 8,
  parameter int         NUM_STAT  = 4,
  parameter logic [7:0] RST_VAL   = 8'h00,
  parameter logic [7:0] UNMAP_VAL = 8'hEE
) (
  input  wire logic                  clk200,
  input  wire logic                  rst,
  spi_reg_bridge_if.slave            bus,
  output      logic [8*NUM_REGS-1:0] reg_o,
  output      logic [NUM_REGS-1:0]   wr_stb_o,
  input  wire logic [8*NUM_STAT-1:0] stat_i,
  output      logic [7:0]            err_cnt_o
);

  bridge_st_t             r_state;
  logic [ADDR_W-1:0]      r_addr;
  logic [8*NUM_REGS-1:0]  r_regs;
  logic [NUM_REGS-1:0]    r_wr_stb;
  logic [7:0]             r_tx;
  logic [7:0]             r_err_cnt;

  bridge_st_t             w_eff_st;
  logic [ADDR_W-1:0]      w_rd_addr;
  logic [7:0]             w_rdata;
  logic                   w_err_inc;

  // A frame start overrides the current state so a coincident byte is the new cmd.
  assign w_eff_st  = bus.frm_start_i ? CMD : r_state;
  assign w_rd_addr = (w_eff_st == CMD) ? bus.rx_data_i[ADDR_W-1:0] : r_addr + 7'd1;
  assign w_err_inc = (bus.frm_start_i && (r_state != IDLE)) ||
                     (!bus.frm_start_i && (r_state == IDLE) && bus.rx_valid_i);

  spi_reg_rdmux #(
    .NUM_REGS  (NUM_REGS),
    .NUM_STAT  (NUM_STAT),
    .UNMAP_VAL (UNMAP_VAL)
  ) u_rdmux (
    .addr  (w_rd_addr),
    .regs  (r_regs),
    .stat  (stat_i),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk200) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_regs    <= {NUM_REGS{RST_VAL}};
      r_wr_stb  <= '0;
      r_tx      <= 8'h00;
      r_err_cnt <= 8'h00;
    end else begin
      r_wr_stb <= '0;
      if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;

      case (w_eff_st)
        IDLE: begin
          r_state <= IDLE;
          r_tx    <= 8'h00;
        end
        CMD: begin
          r_state <= CMD;
          r_tx    <= 8'h00;
          if (bus.rx_valid_i) begin
            r_addr <= bus.rx_data_i[ADDR_W-1:0];
            if (bus.rx_data_i[CMD_RD_BIT]) begin
              r_state <= RD;
              r_tx    <= w_rdata;
            end else begin
              r_state <= WR;
            end
          end
        end
        WR: begin
          r_state <= WR;
          r_tx    <= 8'h00;
          if (bus.rx_valid_i) begin
            r_addr <= r_addr + 7'd1;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (r_addr == ADDR_W'(i)) begin
                r_regs[8*i +: 8] <= bus.rx_data_i;
                r_wr_stb[i]      <= 1'b1;
              end
            end
          end
        end
        RD: begin
          r_state <= RD;
          if (bus.rx_valid_i) begin
            r_addr <= r_addr + 7'd1;
            r_tx   <= w_rdata;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 8'h00;
        end
      endcase

      // Frame end lands after the byte above has been committed.
      if (bus.frm_end_i) begin
        r_state <= IDLE;
        r_tx    <= 8'h00;
      end
    end
  end

  assign bus.tx_data_o = r_tx;
  assign reg_o         = r_regs;
  assign wr_stb_o      = r_wr_stb;
  assign err_cnt_o     = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
//------------------------------------------------------------------------------
// Module : tb_spi_reg_bridge
// Brief  : Directed self-checking bench for spi_reg_bridge.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_reg_bridge;

  logic        clk200;
  logic        rst;
  logic [63:0] reg_o;
  logic [7:0]  wr_stb_o;
  logic [31:0] stat_i;
  logic [7:0]  err_cnt_o;

  int tests;
  int fails;

  spi_reg_bridge_if bus ();

  spi_reg_bridge #(
    .NUM_REGS  (8),
    .NUM_STAT  (4),
    .RST_VAL   (8'h00),
    .UNMAP_VAL (8'hEE)
  ) dut (
    .clk200    (clk200),
    .rst       (rst),
    .bus       (bus.slave),
    .reg_o     (reg_o),
    .wr_stb_o  (wr_stb_o),
    .stat_i    (stat_i),
    .err_cnt_o (err_cnt_o)
  );

  initial clk200 = 1'b0;
  always #5 clk200 = ~clk200;

  task automatic tick();
    @(posedge clk200);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = d;
    tick();
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic frm_start();
    bus.frm_start_i = 1'b1;
    tick();
    bus.frm_start_i = 1'b0;
  endtask

  task automatic frm_end();
    bus.frm_end_i = 1'b1;
    tick();
    bus.frm_end_i = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst             = 1'b1;
    bus.frm_start_i = 1'b0;
    bus.frm_end_i   = 1'b0;
    bus.rx_valid_i  = 1'b0;
    bus.rx_data_i   = 8'h00;
    stat_i          = 32'hC322_113C;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("reset_regs", reg_o, 64'h0);
    check("reset_stb",  {56'h0, wr_stb_o}, 64'h0);
    check("reset_tx",   {56'h0, bus.tx_data_o}, 64'h0);
    check("reset_err",  {56'h0, err_cnt_o}, 64'h0);

    // write burst to reg2/reg3
    frm_start();
    send_byte(8'h02);
    send_byte(8'hA5);
    check("wr_stb2", {56'h0, wr_stb_o}, 64'h04);
    check("wr_reg2", reg_o, 64'h00000000_00A50000);
    send_byte(8'h5A);
    check("wr_stb3", {56'h0, wr_stb_o}, 64'h08);
    check("wr_reg3", reg_o, 64'h00000000_5AA50000);
    tick();
    check("wr_stb_clear", {56'h0, wr_stb_o}, 64'h0);
    frm_end();

    // read burst back
    frm_start();
    send_byte(8'h82);
    check("rd_reg2", {56'h0, bus.tx_data_o}, 64'hA5);
    tick();
    send_byte(8'h00);
    check("rd_reg3", {56'h0, bus.tx_data_o}, 64'h5A);
    frm_end();
    check("rd_idle_tx", {56'h0, bus.tx_data_o}, 64'h0);

    // status and unmapped reads
    frm_start();
    send_byte(8'hC0);
    check("rd_stat0", {56'h0, bus.tx_data_o}, 64'h3C);
    frm_end();
    frm_start();
    send_byte(8'hD0);
    check("rd_unmap50", {56'h0, bus.tx_data_o}, 64'hEE);
    frm_end();
    frm_start();
    send_byte(8'hC3);
    check("rd_stat3", {56'h0, bus.tx_data_o}, 64'hC3);
    send_byte(8'h00);
    check("rd_unmap44", {56'h0, bus.tx_data_o}, 64'hEE);
    frm_end();

    // boundary write at last register
    frm_start();
    send_byte(8'h07);
    send_byte(8'h11);
    check("bnd_stb7", {56'h0, wr_stb_o}, 64'h80);
    send_byte(8'h22);
    check("bnd_stb8", {56'h0, wr_stb_o}, 64'h0);
    send_byte(8'h33);
    check("bnd_stb9", {56'h0, wr_stb_o}, 64'h0);
    check("bnd_regs", reg_o, 64'h11000000_5AA50000);
    frm_end();
    check("bnd_err", {56'h0, err_cnt_o}, 64'h0);

    // protocol errors
    send_byte(8'h99);
    check("err_idle", {56'h0, err_cnt_o}, 64'h1);
    frm_start();
    send_byte(8'h01);
    send_byte(8'h44);
    frm_start();
    check("err_abort", {56'h0, err_cnt_o}, 64'h2);
    send_byte(8'h03);
    send_byte(8'h66);
    check("err_recov_stb", {56'h0, wr_stb_o}, 64'h08);
    check("err_recov_regs", reg_o, 64'h11000000_66A54400);
    frm_end();
    check("err_final", {56'h0, err_cnt_o}, 64'h2);

    // byte coinciding with frame end still commits
    frm_start();
    send_byte(8'h05);
    bus.frm_end_i = 1'b1;
    send_byte(8'h77);
    bus.frm_end_i = 1'b0;
    check("end_byte_stb", {56'h0, wr_stb_o}, 64'h20);
    check("end_byte_regs", reg_o, 64'h11007700_66A54400);
    send_byte(8'h01);
    check("end_now_idle", {56'h0, err_cnt_o}, 64'h3);

    // reset mid write burst
    frm_start();
    send_byte(8'h00);
    send_byte(8'h12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_regs", reg_o, 64'h0);
    check("rst_err",  {56'h0, err_cnt_o}, 64'h0);
    check("rst_stb",  {56'h0, wr_stb_o}, 64'h0);
    send_byte(8'h55);
    check("rst_idle", {56'h0, err_cnt_o}, 64'h1);
    check("rst_no_write", reg_o, 64'h0);
    frm_start();
    send_byte(8'h06);
    send_byte(8'hAB);
    frm_end();
    check("rst_next_frame", reg_o, 64'h00AB0000_00000000);

    // frame start and cmd byte in the same cycle
    bus.frm_start_i = 1'b1;
    send_byte(8'h86);
    bus.frm_start_i = 1'b0;
    check("start_cmd_same", {56'h0, bus.tx_data_o}, 64'hAB);
    send_byte(8'hFF);
    check("start_cmd_next", {56'h0, bus.tx_data_o}, 64'h00);
    frm_end();
    check("final_err", {56'h0, err_cnt_o}, 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
